// File: rtl/blake2s_digest_buf.sv
// blake2s_digest_buf: captures one BLAKE2s digest from the core and replays it byte-by-byte to the host.
module blake2s_digest_buf #(
  parameter int NN_MAX = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] nn_i,
  input  logic       h_v_i,
  input  logic [7:0] h_i,
  input  logic       rd_i,
  input  logic       clr_i,
  output logic [7:0] data_o,
  output logic       data_v_o,
  output logic       ready_o,
  output logic       ovf_o
);
  localparam int PW = $clog2(NN_MAX);
  localparam int LW = $clog2(NN_MAX + 1);
  typedef enum logic [1:0] {IDLE, FILL, READY, DRAIN} state_t;
  state_t          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, waddr;
  logic [LW-1:0]   len_q, len_d, nn_len;
  logic [7:0]      data_q, data_d;
  logic            dv_q, dv_d, ovf_q, ovf_d, we, held, last_wr, last_rd;
  logic [7:0]      store_q [NN_MAX];
  assign held    = (state_q == READY) || (state_q == DRAIN);
  assign nn_len  = (nn_i == 6'd0 || int'(nn_i) > NN_MAX) ? LW'(NN_MAX) : LW'(nn_i);
  assign last_wr = LW'(wr_ptr_q) == len_q - LW'(1);
  assign last_rd = LW'(rd_ptr_q) == len_q - LW'(1);
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    len_d    = len_q;
    data_d   = data_q;
    dv_d     = 1'b0;
    we       = 1'b0;
    waddr    = state_q == IDLE ? '0 : wr_ptr_q;
    case (state_q)
      IDLE: if (h_v_i) begin
        we       = 1'b1;
        wr_ptr_d = PW'(1);
        len_d    = nn_len;
        state_d  = nn_len == LW'(1) ? READY : FILL;
      end
      FILL: if (h_v_i) begin
        we       = 1'b1;
        wr_ptr_d = last_wr ? wr_ptr_q : wr_ptr_q + PW'(1);
        state_d  = last_wr ? READY : FILL;
      end
      default: if (rd_i) begin
        dv_d     = 1'b1;
        data_d   = store_q[rd_ptr_q];
        rd_ptr_d = last_rd ? '0 : rd_ptr_q + PW'(1);
        wr_ptr_d = last_rd ? '0 : wr_ptr_q;
        state_d  = last_rd ? IDLE : DRAIN;
      end
    endcase
    ovf_d = (h_v_i && held) ? 1'b1 : clr_i ? 1'b0 : ovf_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      len_q    <= '0;
      data_q   <= '0;
      dv_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      len_q    <= len_d;
      data_q   <= data_d;
      dv_q     <= dv_d;
      ovf_q    <= ovf_d;
    end
  end
  // Store contents are don't-care after reset, so no reset term here.
  always_ff @(posedge clk) begin
    if (we) store_q[waddr] <= h_i;
  end
  assign data_o   = data_q;
  assign data_v_o = dv_q;
  assign ready_o  = held;
  assign ovf_o    = ovf_q;
endmodule

// File: tb/tb_blake2s_digest_buf.sv
// tb_blake2s_digest_buf: queue-based digest model checked every cycle, plus directed literal checks.
module tb_blake2s_digest_buf;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] nn_i = '0;
  logic       h_v_i = 1'b0, rd_i = 1'b0, clr_i = 1'b0;
  logic [7:0] h_i = '0;
  logic [7:0] data_o;
  logic       data_v_o, ready_o, ovf_o;
  int tests = 0, fails = 0;

  blake2s_digest_buf #(.NN_MAX(32)) dut (
    .clk(clk), .reset(reset), .nn_i(nn_i), .h_v_i(h_v_i), .h_i(h_i), .rd_i(rd_i),
    .clr_i(clr_i), .data_o(data_o), .data_v_o(data_v_o), .ready_o(ready_o), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  logic [7:0] mq[$];
  int         m_len = 32, m_rd = 0;
  logic       m_full = 0, m_dv = 0, m_ovf = 0, m_set;
  logic [7:0] m_do = '0;

  // Model: collect bytes until the digest length is reached, then hand them out in order.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete(); m_full = 0; m_rd = 0; m_dv = 0; m_do = '0; m_ovf = 0;
    end else begin
      m_set = h_v_i && m_full;
      m_dv = 0;
      if (m_full) begin
        if (rd_i) begin
          m_do = mq[m_rd]; m_dv = 1; m_rd++;
          if (m_rd == m_len) begin m_full = 0; mq.delete(); m_rd = 0; end
        end
      end else if (h_v_i) begin
        if (mq.size() == 0) m_len = (nn_i == 0 || nn_i > 32) ? 32 : int'(nn_i);
        mq.push_back(h_i);
        if (mq.size() == m_len) m_full = 1;
      end
      m_ovf = m_set ? 1'b1 : clr_i ? 1'b0 : m_ovf;
    end
  end

  always @(negedge clk)
    chk("cycle", {21'd0, data_o, data_v_o, ready_o, ovf_o}, {21'd0, m_do, m_dv, m_full, m_ovf});

  task automatic cyc(input logic hv, input logic [7:0] h, input logic [5:0] nn, input logic rd, input logic clr);
    h_v_i = hv; h_i = h; nn_i = nn; rd_i = rd; clr_i = clr;
    @(posedge clk); #1;
    h_v_i = 0; h_i = '0; nn_i = '0; rd_i = 0; clr_i = 0;
  endtask

  task automatic idle_gaps();
    while ($urandom_range(0, 2) == 0) cyc(0, 0, 0, 0, 0);
  endtask

  initial begin
    repeat (3) cyc(0, 0, 0, 0, 0);
    chk("reset_outs", {data_o, data_v_o, ready_o, ovf_o}, 0);
    reset = 0;
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) begin
      cyc(1, 8'(i), 6'd32, 0, 0);
      if (i == 30) chk("rdy_early", ready_o, 0);
    end
    chk("rdy_32", ready_o, 1);
    for (int i = 0; i < 32; i++) begin
      cyc(0, 0, 0, 1, 0);
      chk("rd_v", data_v_o, 1);
      chk("rd_byte", data_o, i);
      chk("rd_rdy", ready_o, i != 31);
    end
    cyc(1, 8'hA5, 6'd1, 0, 0);
    chk("one_rdy", ready_o, 1);
    cyc(0, 0, 0, 1, 0);
    chk("one_byte", {data_o, data_v_o, ready_o}, {8'hA5, 1'b1, 1'b0});
    cyc(0, 0, 0, 1, 0);
    chk("one_norepeat", data_v_o, 0);
    for (int i = 0; i < 32; i++) begin
      cyc(1, 8'(8'h40 + i), 6'd0, 0, 0);
      chk("gap_rdy", ready_o, i == 31);
      if (i != 31) cyc(0, 0, 0, 0, 0);
    end
    for (int i = 0; i < 32; i++) begin
      idle_gaps();
      cyc(0, 0, 0, 1, 0);
      chk("gap_byte", data_o, 8'h40 + i);
    end
    for (int i = 0; i < 4; i++) cyc(1, 8'(8'h11 + i), 6'd4, 0, 0);
    cyc(1, 8'hFF, 6'd0, 0, 0);
    chk("ovf_set", ovf_o, 1);
    for (int i = 0; i < 4; i++) begin
      idle_gaps();
      cyc(0, 0, 0, 1, 0);
      chk("ovf_byte", data_o, 8'h11 + i);
    end
    chk("ovf_sticky", ovf_o, 1);
    cyc(0, 0, 0, 0, 1);
    chk("ovf_clr", ovf_o, 0);
    for (int i = 0; i < 3; i++) cyc(1, 8'(8'h31 + i), 6'd3, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(1, 8'h77, 6'd2, 1, 0);
    chk("last_rd_drop", {data_o, ready_o, ovf_o}, {8'h33, 1'b0, 1'b1});
    cyc(1, 8'h88, 6'd2, 0, 0);
    cyc(1, 8'h99, 6'd2, 0, 0);
    chk("new_rdy", ready_o, 1);
    cyc(0, 0, 0, 1, 0);
    chk("new_b0", data_o, 8'h88);
    cyc(0, 0, 0, 1, 0);
    chk("new_b1", data_o, 8'h99);
    for (int i = 0; i < 10; i++) cyc(1, 8'(8'hE0 + i), 6'd16, 0, 0);
    reset = 1;
    #1 chk("async_rst", {data_o, data_v_o, ready_o, ovf_o}, 0);
    @(posedge clk); #1;
    reset = 0;
    for (int i = 0; i < 16; i++) cyc(1, 8'(8'h20 + i), 6'd16, 0, 0);
    chk("fresh_rdy", ready_o, 1);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 0, 1, 0);
      chk("fresh_byte", data_o, 8'h20 + i);
    end
    repeat (600) cyc(1'($urandom_range(0, 1)), 8'($urandom), 6'($urandom_range(0, 63)),
                     1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
